// File: rtl/frame_classifier.sv
// Ingress classifier: tags each frame as IPv4/TCP, checks its beat count against
// the IPv4 total length, and forwards beats through a fully registered skid buffer.
module frame_classifier #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DATA   = 8,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cls_en,
  input  logic [DATA_WIDTH*NUM_DATA-1:0] data_in,
  input  logic                           tvalid_in,
  input  logic                           tlast_in,
  input  logic                           tready_in,
  output logic                           tready_out,
  output logic [DATA_WIDTH*NUM_DATA-1:0] data_out,
  output logic                           tvalid_out,
  output logic                           tlast_out,
  output logic                           cls_tcp,
  output logic [15:0]                    ip_len,
  output logic                           len_err,
  output logic [31:0]                    frm_cnt,
  output logic [31:0]                    tcp_cnt,
  output logic [31:0]                    err_cnt
);

  localparam int BW = DATA_WIDTH * NUM_DATA;

  typedef enum logic {S_HEAD, S_BODY} state_t;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
    logic          tcp;
    logic [15:0]   len;
    logic          err;
  } beat_t;

  state_t               state_q;
  logic                 tcp_q, ipv4_q, en_q;
  logic [15:0]          len_q;
  logic [CNT_WIDTH-1:0] exp_q, cnt_q;

  beat_t main_q, skid_q, in_beat;
  logic  main_v, skid_v, rdy_q, skid_next;
  logic  acc, out_xfer;

  logic [31:0] frm_cnt_q, tcp_cnt_q, err_cnt_q;

  // Header decode straight off the incoming beat
  logic                 hdr, ipv4_c, tcp_c;
  logic [15:0]          len_c;
  logic [16:0]          len_sum;
  logic [CNT_WIDTH-1:0] exp_c, cnt_inc;
  logic                 beat_en, beat_ipv4;
  logic [CNT_WIDTH-1:0] beat_cnt, beat_exp;

  assign acc      = tvalid_in && rdy_q;
  assign out_xfer = main_v && tready_in;

  always_comb begin
    hdr       = (state_q == S_HEAD);
    ipv4_c    = (data_in[103:96] == 8'h08) && (data_in[111:104] == 8'h00);
    tcp_c     = ipv4_c && (data_in[191:184] == 8'h06);
    len_c     = ipv4_c ? {data_in[135:128], data_in[143:136]} : 16'h0000;
    len_sum   = {1'b0, len_c} + 17'd45;
    exp_c     = CNT_WIDTH'(len_sum >> 5);
    cnt_inc   = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    beat_en   = hdr ? cls_en : en_q;
    beat_ipv4 = hdr ? ipv4_c : ipv4_q;
    beat_exp  = hdr ? exp_c : exp_q;
    beat_cnt  = hdr ? CNT_WIDTH'(1) : cnt_inc;

    in_beat      = '0;
    in_beat.data = data_in;
    in_beat.last = tlast_in;
    in_beat.tcp  = hdr ? (cls_en && tcp_c) : tcp_q;
    in_beat.len  = hdr ? len_c : len_q;
    in_beat.err  = tlast_in && beat_en && beat_ipv4 && (beat_cnt != beat_exp);
  end

  // Per-frame context; body beats simply re-latch the values they already carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_HEAD;
      tcp_q   <= 1'b0;
      ipv4_q  <= 1'b0;
      en_q    <= 1'b0;
      len_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
    end else if (acc) begin
      tcp_q   <= in_beat.tcp;
      ipv4_q  <= beat_ipv4;
      en_q    <= beat_en;
      len_q   <= in_beat.len;
      exp_q   <= beat_exp;
      cnt_q   <= beat_cnt;
      state_q <= tlast_in ? S_HEAD : S_BODY;
    end
  end

  always_comb begin
    skid_next = skid_v ? !out_xfer : (acc && main_v && !out_xfer);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the data registers are reset as well because data_out must read 0 in reset.
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      if (skid_v) begin
        if (out_xfer) main_q <= skid_q;
      end else if (acc) begin
        if (!main_v || out_xfer) begin
          main_q <= in_beat;
          main_v <= 1'b1;
        end else begin
          skid_q <= in_beat;
        end
      end else if (out_xfer) begin
        main_v <= 1'b0;
      end
      skid_v <= skid_next;
      rdy_q  <= !skid_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frm_cnt_q <= '0;
      tcp_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (out_xfer && main_q.last) begin
      frm_cnt_q <= frm_cnt_q + 32'd1;
      tcp_cnt_q <= tcp_cnt_q + {31'd0, main_q.tcp};
      err_cnt_q <= err_cnt_q + {31'd0, main_q.err};
    end
  end

  assign tready_out = rdy_q;
  assign data_out   = main_q.data;
  assign tvalid_out = main_v;
  assign tlast_out  = main_q.last;
  assign cls_tcp    = main_q.tcp;
  assign ip_len     = main_q.len;
  assign len_err    = main_q.err;
  assign frm_cnt    = frm_cnt_q;
  assign tcp_cnt    = tcp_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule
